// File: rtl/bcd_stopwatch.sv
// Purpose : M:SS BCD stopwatch with start/stop/clear control and a wrap pulse at MIN_MAX:59 -> 0:00.
// Latency : the count updates on the edge that detects a tick rise (1 cycle), or 3 cycles when TICK_SYNC_EN is defined.
// Backpres: none; inputs are edge-detected levels, and tick/command edges arriving outside their state are dropped.
//
// Ports: clk, reset (sync, active-low), tick_in (count level), start_stop (command level),
//        clear (zero when not running) -> sec_ones/sec_tens/min_ones (BCD digits),
//        state (00 IDLE, 01 RUN, 10 PAUSE), running, wrap (one-cycle rollover pulse).
// Config: define TICK_SYNC_EN to put a two-flop synchronizer on tick_in ahead of edge detection.
module bcd_stopwatch #(
    parameter int MIN_MAX = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [1:0] state,
    output logic       running,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    localparam logic [3:0] MIN_MAX_L = 4'(MIN_MAX);

    state_t     state_q;
    logic [3:0] sec_ones_q, sec_tens_q, min_ones_q;
    logic [3:0] sec_ones_d, sec_tens_d, min_ones_d;
    logic       running_q, wrap_q, wrap_d;
    logic       tick_d_q, ss_d_q;
    logic       tick_src;
    logic       tick_ev, cmd_ev;

`ifdef TICK_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= tick_in;
            sync2_q <= sync1_q;
        end
    end

    assign tick_src = sync2_q;
`else
    assign tick_src = tick_in;
`endif

    assign tick_ev = tick_src & ~tick_d_q;
    assign cmd_ev  = start_stop & ~ss_d_q;

    // Incremented count with digit carries; applied only on a tick event in RUN.
    always_comb begin
        sec_ones_d = sec_ones_q + 4'd1;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        wrap_d     = 1'b0;
        if (sec_ones_q == 4'd9) begin
            sec_ones_d = 4'd0;
            if (sec_tens_q == 4'd5) begin
                sec_tens_d = 4'd0;
                if (min_ones_q == MIN_MAX_L) begin
                    min_ones_d = 4'd0;
                    wrap_d     = 1'b1;
                end else begin
                    min_ones_d = min_ones_q + 4'd1;
                end
            end else begin
                sec_tens_d = sec_tens_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            running_q  <= 1'b0;
            wrap_q     <= 1'b0;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            tick_d_q   <= 1'b0;
            // Held high through reset so a start_stop already high at release is not a command.
            ss_d_q     <= 1'b1;
        end else begin
            tick_d_q <= tick_src;
            ss_d_q   <= start_stop;
            wrap_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        sec_ones_q <= 4'd0;
                        sec_tens_q <= 4'd0;
                        min_ones_q <= 4'd0;
                    end else if (cmd_ev) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    // clear is deliberately ignored while running.
                    if (tick_ev) begin
                        sec_ones_q <= sec_ones_d;
                        sec_tens_q <= sec_tens_d;
                        min_ones_q <= min_ones_d;
                        wrap_q     <= wrap_d;
                    end
                    if (cmd_ev) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end
                end
                PAUSE: begin
                    // clear wins over a simultaneous command; ticks are dropped.
                    if (clear) begin
                        state_q    <= IDLE;
                        sec_ones_q <= 4'd0;
                        sec_tens_q <= 4'd0;
                        min_ones_q <= 4'd0;
                    end else if (cmd_ev) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign sec_ones = sec_ones_q;
    assign sec_tens = sec_tens_q;
    assign min_ones = min_ones_q;
    assign state    = state_q;
    assign running  = running_q;
    assign wrap     = wrap_q;

endmodule

// File: doc/bcd_stopwatch.md
BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 Parameter: MIN_MAX, default 9, highest value of the minutes digit (range 1..9).
REQ-002 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset.
REQ-004 Port: tick_in  input  1  slow toggling level from the clock-divider stage; each rising edge is one count event.
REQ-005 Port: start_stop  input  1  level control; each rising edge is one start/stop command.
REQ-006 Port: clear  input  1  level; returns the counter to zero when not running.
REQ-007 Port: sec_ones  output  4  BCD seconds units, 0..9.
REQ-008 Port: sec_tens  output  4  BCD seconds tens, 0..5.
REQ-009 Port: min_ones  output  4  BCD minutes, 0..MIN_MAX.
REQ-010 Port: state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10; 11 is never driven.
REQ-011 Port: running  output  1  high when state is RUN.
REQ-012 Port: wrap  output  1  one-cycle pulse on rollover from MIN_MAX:59 to 0:00.

Function
REQ-013 Tick event SHALL be tick_in sampled high while its registered copy tick_d is low; tick_d SHALL register tick_in every cycle.
REQ-014 Command event SHALL be start_stop high while its registered copy ss_d is low.
REQ-015 FSM transitions SHALL be:
- IDLE --command--> RUN
- RUN --command--> PAUSE
- PAUSE --command--> RUN
- IDLE or PAUSE with clear high --> IDLE
REQ-016 In PAUSE, clear SHALL take priority over a simultaneous command; the result is IDLE with the count zeroed.
REQ-017 In RUN, clear SHALL be ignored.
REQ-018 In RUN, each tick event SHALL update the count on the same clk edge that detects it, so the outputs change one cycle after tick_in is first sampled high.
- sec_ones: 9 -> 0 with carry to sec_tens.
- sec_tens: 5 -> 0 with carry to min_ones.
- min_ones: MIN_MAX -> 0.
REQ-019 On the tick at MIN_MAX:59, the count SHALL become 0:00 and wrap SHALL be high for exactly one cycle; the FSM stays in RUN.
REQ-020 A tick event and a command in the same cycle in RUN SHALL count the tick and enter PAUSE.
REQ-021 A tick event and a command in the same cycle in PAUSE SHALL not count the tick and SHALL enter RUN.
REQ-022 Tick events in IDLE or PAUSE SHALL be discarded; the count holds.
REQ-023 All outputs SHALL be registered; no BCD digit SHALL ever hold an out-of-range value.

Reset
REQ-024 On a clk edge with reset=0, the block SHALL set:
- sec_ones, sec_tens, min_ones = 0
- state = IDLE, running = 0, wrap = 0
- tick_d = 0
- ss_d = 1, so a start_stop held high through reset issues no command.
REQ-025 Reset SHALL override all other inputs in any state, including mid-count in RUN.
REQ-026 Reset SHALL have no effect between clk edges.

Configuration
REQ-027 Macro TICK_SYNC_EN: when defined, tick_in SHALL pass through a two-flop synchronizer before edge detection, adding exactly 2 cycles of tick latency (outputs change 3 cycles after tick_in rises).
REQ-028 When TICK_SYNC_EN is undefined, the synchronizer SHALL be absent, with latency per REQ-018.
REQ-029 Synchronizer flops SHALL reset to 0.
REQ-030 All other behaviour SHALL be identical with and without TICK_SYNC_EN.

Verification
REQ-031 tick_in toggling every 5 clk; reset low 2 cycles, then start_stop pulse; after 10 tick_in rising edges -> sec_ones=0, sec_tens=1, min_ones=0, running=1.
REQ-032 MIN_MAX=9, running, 599 ticks -> 9:59; next tick -> 0:00, wrap=1 for one cycle, state=01.
REQ-033 Running at 0:07, command -> state=10; 3 ticks -> still 0:07; clear -> 0:00, state=00.
REQ-034 Running, clear held 20 cycles -> count keeps advancing, state=01; command and tick in the same cycle at 0:04 -> 0:05, state=10.
REQ-035 start_stop held high across reset release -> state stays 00; reset asserted mid-count at 0:42 -> 0:00, state=00 on the next edge.
REQ-036 With TICK_SYNC_EN defined, tick_in rising at cycle n -> sec_ones increments at edge n+3 instead of n+1.
